bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-add-3). Feeds one or more bcd7seg
//   decoders: accepts an unsigned binary word via a valid/ready handshake and
//   emits DIGITS 4-bit BCD nibbles. Leading zeros are replaced with the blank
//   code 4'b1111, which the seg decoder drives as all segments off.
//   Sits between counter/ALU result logic and the 7-segment display path.
// PARAMETERS
//   WIDTH    8  binary input width (>=1)
//   DIGITS   3  BCD digits produced; must satisfy 10**DIGITS > 2**WIDTH-1 (elab $error otherwise)
//   BLANK_LZ 1  1 = replace leading zero digits with 4'hF; 0 = show all zeros
// PORTS
//   clk        in   1           rising-edge clock
//   rst_n      in   1           synchronous reset, active low
//   in_valid   in   1           bin is valid
//   in_ready   out  1           converter idle and able to accept
//   bin        in   WIDTH       unsigned binary value
//   out_valid  out  1           one-cycle pulse: digits holds a new result
//   digits     out  DIGITS*4    BCD digits; [3:0] = units, [7:4] = tens, ...
// BEHAVIOUR
//   - Reset (rst_n==0 at an edge): state=IDLE, digits=all 4'hF (display dark), out_valid=0,
//     shift count=0. in_ready=1 from the first cycle after reset release.
//   - in_ready = (state==IDLE). Transfer occurs on an edge with in_valid && in_ready.
//   - FSM: IDLE -> SHIFT on transfer (latch bin into shift reg, clear BCD accumulator, cnt=0).
//     SHIFT: each cycle, every accumulator nibble >=5 gets +3, then {acc,shreg} shifts
//     left 1 (MSB of bin first); cnt++. After WIDTH SHIFT cycles -> OUT.
//     OUT: digits <= blanked(acc); out_valid=1 for exactly this cycle; -> IDLE.
//   - Latency: transfer at edge E0; out_valid high for the cycle following edge E(WIDTH+1).
//     Throughput: one conversion per WIDTH+2 cycles (in_ready high again in IDLE cycle after OUT).
//   - in_valid while in_ready==0 is ignored; bin need not be held after transfer.
//   - digits holds the last result between conversions; changes only on the OUT edge.
//   - Blanking (BLANK_LZ=1): scanning from the most significant digit, each zero digit
//     is 4'hF until the first nonzero digit; the units digit is never blanked (value 0 -> ...F,F,0).
//   - Accumulator is DIGITS*4 bits; add-3 is applied only to nibbles within it; no
//     overflow possible given the parameter constraint.
//   - rst_n low during SHIFT/OUT aborts the conversion: no out_valid, digits -> all 4'hF.
//   - Output values never contain 4'hA..4'hE.
// STRUCTURE
//   - Shared package npc_disp_pkg: localparam BCD_BLANK = 4'b1111; state enum
//     {S_IDLE, S_SHIFT, S_OUT} (2-bit); reused by the display mux and bcd7seg users.
//   - One sub-module: bcd_add3 (combinational, 4-bit in/out: n>=5 ? n+3 : n),
//     instantiated DIGITS times via generate.
//   - Counter width $clog2(WIDTH+1); all registers in one always @(posedge clk) block.
// TESTING
//   1. Reset, then bin=0, WIDTH=8,DIGITS=3 -> out_valid 10 cycles after transfer edge, digits={F,F,0}.
//   2. bin=255 -> digits={2,5,5}; bin=100 -> {1,0,0}; bin=9 -> {F,F,9}; bin=10 -> {F,1,0}.
//   3. BLANK_LZ=0, bin=7 -> digits={0,0,7}; bin=0 -> {0,0,0}.
//   4. in_valid held high continuously with bin stepping 0..255 -> every value converted
//      exactly once, in_ready low during conversion, one out_valid per transfer, compare to
//      reference model (bin/100, bin/10%10, bin%10 with blanking).
//   5. Change bin mid-conversion while in_ready=0 -> result reflects the latched value only.
//   6. Assert rst_n=0 during SHIFT cycle 4 -> no out_valid, digits={F,F,F}, in_ready=1
//      after release; next conversion of 42 -> {F,4,2}.

Source files
------------

// File: rtl/npc_disp_pkg.sv
// npc_disp_pkg: shared display constants and converter state encoding
package npc_disp_pkg;
    localparam logic [3:0] BCD_BLANK = 4'b1111;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_OUT} state_t;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: shift-add-3 nibble correction (n>=5 ? n+3 : n)
//   i_nib  in   4  BCD nibble before shift
//   o_nib  out  4  corrected nibble
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);
    assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter with leading-zero blanking
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input handshake, bin latched on transfer
//   out_valid           one-cycle pulse when digits updates
//   digits              DIGITS BCD nibbles, [3:0] = units, blank nibble = 4'hF
module bin2bcd_seq #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin,
    output logic                  out_valid,
    output logic [DIGITS*4-1:0]   digits
);
    import npc_disp_pkg::*;
    localparam int DW = DIGITS * 4;
    localparam int CW = $clog2(WIDTH + 1);
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_sh;
    logic [DW-1:0]   r_acc;
    logic [DW-1:0]   w_adj;
    logic [DW-1:0]   w_blank;
    logic [DIGITS-1:0] w_nz;
    if (64'd10 ** DIGITS <= 64'd2 ** WIDTH - 64'd1) begin : g_bad
        $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end
    // a digit is blanked only when it and every more significant digit are zero
    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        bcd_add3 u_add3 (.i_nib(r_acc[4*d +: 4]), .o_nib(w_adj[4*d +: 4]));
        assign w_nz[d] = |r_acc[4*d +: 4];
        assign w_blank[4*d +: 4] = (BLANK_LZ && d != 0 && ~|w_nz[DIGITS-1:d]) ? BCD_BLANK : r_acc[4*d +: 4];
    end
    assign in_ready = (r_state == S_IDLE);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sh      <= '0;
            r_acc     <= '0;
            digits    <= {DIGITS{BCD_BLANK}};
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_state <= S_SHIFT;
                    r_sh    <= bin;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end
                S_SHIFT: begin
                    {r_acc, r_sh} <= {w_adj, r_sh} << 1;
                    r_cnt         <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) r_state <= S_OUT;
                end
                S_OUT: begin
                    digits    <= w_blank;
                    out_valid <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and sweep checks of bin2bcd_seq against a decimal model
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  bin = 8'd0;
    logic        rdy1, ov1, rdy0, ov0;
    logic [11:0] dig1, dig0;
    int checks = 0;
    int errors = 0;
    int pulses = 0;
    always #5 clk = ~clk;
    bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .bin(bin), .out_valid(ov1), .digits(dig1));
    bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .bin(bin), .out_valid(ov0), .digits(dig0));
    function automatic logic [11:0] conv(input int v, input bit bl);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        if (bl && h == 4'd0) begin
            h = 4'hF;
            if (t == 4'd0) t = 4'hF;
        end
        return {h, t, u};
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask
    // model: a transfer at edge k produces the result at edge k+9, busy until then
    int   cyc = 0, due = 0, m_lat = 0;
    bit   busy = 1'b0, armed = 1'b0, m_ov = 1'b0;
    logic [11:0] m_d1 = 12'hFFF, m_d0 = 12'hFFF;
    always @(posedge clk) begin
        m_ov <= 1'b0;
        if (!rst_n) begin
            busy  <= 1'b0;
            m_d1  <= 12'hFFF;
            m_d0  <= 12'hFFF;
            armed <= 1'b1;
        end else if (busy) begin
            if (cyc == due) begin
                busy <= 1'b0;
                m_ov <= 1'b1;
                m_d1 <= conv(m_lat, 1'b1);
                m_d0 <= conv(m_lat, 1'b0);
            end
        end else if (in_valid) begin
            busy  <= 1'b1;
            due   <= cyc + 9;
            m_lat <= int'(bin);
        end
        cyc <= cyc + 1;
    end
    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready", 32'(rdy1), 32'(!busy));
            chk("in_ready_nb", 32'(rdy0), 32'(!busy));
            chk("out_valid", 32'(ov1), 32'(m_ov));
            chk("out_valid_nb", 32'(ov0), 32'(m_ov));
            chk("digits", 32'(dig1), 32'(m_d1));
            chk("digits_nb", 32'(dig0), 32'(m_d0));
        end
        if (ov1 === 1'b1) pulses++;
    end
    task automatic wait_out(input string name, output int lat);
        lat = 1;
        while (ov1 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_seen"}, 32'(ov1), 32'd1);
    endtask
    task automatic run(input int v, input logic [11:0] e1, input logic [11:0] e0);
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        bin = 8'(v);
        @(negedge clk);
        in_valid = 1'b0;
        bin = 8'hA5;
        wait_out($sformatf("run%0d", v), lat);
        chk($sformatf("latency_%0d", v), 32'(lat), 32'd10);
        chk($sformatf("lit_blank_%0d", v), 32'(dig1), 32'(e1));
        chk($sformatf("lit_noblank_%0d", v), 32'(dig0), 32'(e0));
    endtask
    initial begin
        int lat, v, guard;
        bit tx;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(rdy1), 32'd1);
        chk("reset_digits", 32'(dig1), 32'hFFF);
        chk("reset_valid", 32'(ov1), 32'd0);
        run(0,   12'hFF0, 12'h000);
        run(255, 12'h255, 12'h255);
        run(100, 12'h100, 12'h100);
        run(9,   12'hFF9, 12'h009);
        run(10,  12'hF10, 12'h010);
        run(7,   12'hFF7, 12'h007);
        // bin changes and in_valid stays high while busy: only 123 is converted
        @(negedge clk);
        in_valid = 1'b1;
        bin = 8'd123;
        @(negedge clk);
        bin = 8'd200;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        wait_out("midchange", lat);
        chk("midchange_digits", 32'(dig1), 32'h123);
        chk("midchange_digits_nb", 32'(dig0), 32'h123);
        // back-to-back sweep 0..255 with in_valid held high
        @(negedge clk);
        pulses = 0;
        in_valid = 1'b1;
        bin = 8'd0;
        v = 0;
        guard = 0;
        tx = rdy1;
        while (v < 256 && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (tx) begin
                v++;
                bin = 8'(v);
                if (v == 256) in_valid = 1'b0;
            end
            tx = rdy1;
        end
        chk("sweep_transfers", 32'(v), 32'd256);
        repeat (12) @(negedge clk);
        chk("sweep_pulses", 32'(pulses), 32'd256);
        chk("sweep_last", 32'(dig1), 32'h255);
        // reset during the shift phase aborts the conversion
        @(negedge clk);
        in_valid = 1'b1;
        bin = 8'd77;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_digits", 32'(dig1), 32'hFFF);
        chk("abort_digits_nb", 32'(dig0), 32'hFFF);
        chk("abort_valid", 32'(ov1), 32'd0);
        chk("abort_ready", 32'(rdy1), 32'd1);
        pulses = 0;
        repeat (12) @(negedge clk);
        chk("abort_no_pulse", 32'(pulses), 32'd0);
        run(42, 12'hF42, 12'h042);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end
endmodule
